// File: rtl/sram_fault_model.sv
// Single-port synchronous SRAM model with one runtime-loadable fault
// (stuck-at, transition, idempotent coupling) for exercising BIST controllers.
module sram_fault_model #(
   parameter int DATA_W = 2,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              we_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   input  logic              fault_load,
   input  logic [1:0]        fault_mode,
   input  logic [ADDR_W-1:0] fault_addr,
   input  logic [BIT_W-1:0]  fault_bit,
   input  logic              fault_val,
   input  logic [ADDR_W-1:0] aggr_addr
);

   typedef enum logic [1:0] {
      MODE_NONE = 2'd0,
      MODE_SAF  = 2'd1,
      MODE_TF   = 2'd2,
      MODE_CFID = 2'd3
   } mode_t;

   logic [DATA_W-1:0] mem [DEPTH];

   mode_t             cfg_mode;
   logic [ADDR_W-1:0] cfg_addr;
   logic [ADDR_W-1:0] cfg_aggr;
   logic [BIT_W-1:0]  cfg_bit;
   logic              cfg_val;

   logic              addr_ok;
   logic              victim_ok;
   logic              aggr_ok;
   logic              do_rd;
   logic              do_wr;
   logic              hit;
   logic              cf_fire;
   logic [DATA_W-1:0] vmask;
   logic [DATA_W-1:0] fval_word;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] vic_cur;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] victim_word;

   // vmask is all-zero whenever the configured victim cannot exist, which
   // makes every fault path below collapse to plain memory behaviour.
   always_comb begin
      addr_ok   = 32'(address) < 32'(DEPTH);
      victim_ok = (32'(cfg_addr) < 32'(DEPTH)) && (32'(cfg_bit) < 32'(DATA_W));
      aggr_ok   = (32'(cfg_aggr) < 32'(DEPTH)) && (cfg_aggr != cfg_addr);
      vmask     = victim_ok ? (DATA_W'(1) << cfg_bit) : '0;
      fval_word = cfg_val ? vmask : '0;
      do_rd     = !cs_n && we_n;
      do_wr     = !cs_n && !we_n && addr_ok;
      hit       = victim_ok && (address == cfg_addr);
      cur       = addr_ok ? mem[address] : '0;
      vic_cur   = victim_ok ? mem[cfg_addr] : '0;

      rd_word = cur;
      if (cfg_mode == MODE_SAF && hit) begin
         rd_word = (cur & ~vmask) | fval_word;
      end

      wr_word = data_in;
      if (cfg_mode == MODE_SAF && hit) begin
         wr_word = (data_in & ~vmask) | fval_word;
      end else if (cfg_mode == MODE_TF && hit &&
                   ((cur & vmask) != fval_word) &&
                   ((data_in & vmask) == fval_word)) begin
         // Transition toward fault_val fails: keep the stored bit.
         wr_word = (data_in & ~vmask) | (cur & vmask);
      end

      // Rising edge (0->1) on the aggressor bit forces the victim bit.
      cf_fire = (cfg_mode == MODE_CFID) && victim_ok && aggr_ok && do_wr &&
                (address == cfg_aggr) &&
                ((cur & vmask) == '0) && ((data_in & vmask) != '0);
      victim_word = (vic_cur & ~vmask) | fval_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
         rd_valid <= 1'b0;
         cfg_mode <= MODE_NONE;
         cfg_addr <= '0;
         cfg_aggr <= '0;
         cfg_bit  <= '0;
         cfg_val  <= 1'b0;
      end else begin
         rd_valid <= do_rd;
         if (do_rd) begin
            data_out <= rd_word;
         end
         if (do_wr) begin
            mem[address] <= wr_word;
         end
         if (cf_fire) begin
            mem[cfg_addr] <= victim_word;
         end
         // New config takes effect from the next edge on.
         if (fault_load) begin
            cfg_mode <= mode_t'(fault_mode);
            cfg_addr <= fault_addr;
            cfg_aggr <= aggr_addr;
            cfg_bit  <= fault_bit;
            cfg_val  <= fault_val;
         end
      end
   end

endmodule
